// File: rtl/ray_sched_pkg.sv
// Shared types and float helpers for the closest-hit scheduler.
// Float helpers take a 64-bit container so one package serves both widths.
package ray_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUTPUT
  } state_t;

  localparam logic [31:0] FLOAT_POS_INF_32 = 32'h7f80_0000;
  localparam logic [63:0] FLOAT_POS_INF_64 = 64'h7ff0_0000_0000_0000;

  typedef struct packed {
    logic [63:0] t;
    logic [15:0] idx;
    logic        miss;
  } hit_rec_t;

  function automatic logic [63:0] float_pos_inf(input int size);
    return (size == 64) ? FLOAT_POS_INF_64 : {32'h0, FLOAT_POS_INF_32};
  endfunction

  function automatic logic is_valid_hit(
    input logic [63:0] t,
    input logic        undef,
    input int          size
  );
    logic sign;
    logic exp_ones;
    logic nz;
    if (size == 64) begin
      sign     = t[63];
      exp_ones = &t[62:52];
      nz       = |t[62:0];
    end else begin
      sign     = t[31];
      exp_ones = &t[30:23];
      nz       = |t[30:0];
    end
    return !undef && !sign && !exp_ones && nz;
  endfunction

endpackage

// File: rtl/obj_fetch_skid.sv
// Two-entry buffer between the object RAM and the intersector input.
// Head entry is registered and drives the downstream stream directly.
module obj_fetch_skid #(
  parameter int W = 193
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;

  assign dout = e0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0    <= '0;
      e1    <= '0;
      count <= 2'd0;
      valid <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else e1 <= din;
          count <= count + 2'd1;
          valid <= 1'b1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
          valid <= (count == 2'd2);
        end
        2'b11: begin
          if (count == 2'd2) begin
            e0 <= e1;
            e1 <= din;
          end else begin
            e0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ray_scene_sched.sv
// Closest-hit scheduler: streams every scene object past one ray
// through the intersector and reports the nearest valid t.
module ray_scene_sched
  import ray_sched_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int IDX_W = 10
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [IDX_W-1:0]  num_objs,
  input  logic [6*SIZE-1:0] ray_axis_tdata,
  input  logic              ray_axis_tvalid,
  output logic              ray_axis_tready,
  output logic              mem_rd_en,
  output logic [IDX_W-1:0]  mem_addr,
  input  logic [6*SIZE-1:0] mem_rdata,
  input  logic              mem_is_cylinder,
  output logic [6*SIZE-1:0] isect_obj_tdata,
  output logic              isect_obj_is_cylinder,
  output logic              isect_obj_tvalid,
  input  logic              isect_obj_tready,
  output logic [6*SIZE-1:0] isect_ray_tdata,
  output logic              isect_ray_tvalid,
  input  logic              isect_ray_tready,
  input  logic [SIZE-1:0]   t_tdata,
  input  logic              t_undef,
  input  logic              t_tvalid,
  output logic              t_tready,
  output logic [SIZE-1:0]   hit_t,
  output logic [IDX_W-1:0]  hit_idx,
  output logic              hit_miss,
  output logic              hit_tvalid,
  input  logic              hit_tready,
  output logic              err_unexpected
);

  localparam int DW = 6 * SIZE;
  localparam int CW = IDX_W + 1;
  localparam logic [63:0] INF64 = float_pos_inf(SIZE);
  localparam logic [SIZE-1:0] INF = INF64[SIZE-1:0];

  state_t          state;
  logic [DW-1:0]   ray_q;
  logic [CW-1:0]   num_q;
  logic [CW-1:0]   issued;
  logic [CW-1:0]   fetched;
  logic [CW-1:0]   returned;
  logic [SIZE-1:0] best_t;
  logic [IDX_W-1:0] best_idx;
  logic            found;
  logic            rd_q;

  logic [1:0]      sk_cnt;
  logic            sk_vld;
  logic [DW:0]     sk_dout;

  logic            accept;
  logic            beat;
  logic            fetch;
  logic [2:0]      occ;
  logic            res_ok;
  logic            upd;
  logic [63:0]     t64;
  logic [CW-1:0]   ret_nx;
  logic [SIZE-1:0] nb_t;
  logic [IDX_W-1:0] nb_idx;
  logic            nb_found;

  assign accept = (state == IDLE) & ray_axis_tready & ray_axis_tvalid;
  assign beat   = sk_vld & isect_obj_tready & isect_ray_tready;

  // A pop this cycle frees a slot for the read issued now.
  assign occ   = 3'(sk_cnt) + 3'(rd_q) - 3'(beat);
  assign fetch = (state == ISSUE) & (fetched < num_q) & (occ < 3'd2);

  // First read overlaps the accept cycle to reach a 2-cycle first issue.
  assign mem_rd_en = fetch | (accept & (num_objs != '0));
  assign mem_addr  = (state == ISSUE) ? fetched[IDX_W-1:0] : '0;

  obj_fetch_skid #(.W(DW + 1)) u_skid (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (rd_q),
    .din   ({mem_is_cylinder, mem_rdata}),
    .pop   (beat),
    .dout  (sk_dout),
    .valid (sk_vld),
    .count (sk_cnt)
  );

  assign {isect_obj_is_cylinder, isect_obj_tdata} = sk_dout;
  assign isect_obj_tvalid = sk_vld;
  assign isect_ray_tvalid = sk_vld;
  assign isect_ray_tdata  = ray_q;

  assign t64    = 64'(t_tdata);
  assign res_ok = t_tvalid & ((state == ISSUE) | (state == DRAIN))
                & (returned < issued);
  assign upd    = res_ok & is_valid_hit(t64, t_undef, SIZE)
                & (t_tdata[SIZE-2:0] < best_t[SIZE-2:0]);
  assign ret_nx = returned + CW'(res_ok);

  assign nb_t     = upd ? t_tdata : best_t;
  assign nb_idx   = upd ? returned[IDX_W-1:0] : best_idx;
  assign nb_found = upd | found;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= IDLE;
      ray_q           <= '0;
      num_q           <= '0;
      issued          <= '0;
      fetched         <= '0;
      returned        <= '0;
      best_t          <= '0;
      best_idx        <= '0;
      found           <= 1'b0;
      rd_q            <= 1'b0;
      ray_axis_tready <= 1'b0;
      t_tready        <= 1'b0;
      hit_t           <= '0;
      hit_idx         <= '0;
      hit_miss        <= 1'b1;
      hit_tvalid      <= 1'b0;
      err_unexpected  <= 1'b0;
    end else begin
      t_tready <= 1'b1;
      rd_q     <= mem_rd_en;
      if (mem_rd_en) fetched <= fetched + CW'(1);
      if (beat) issued <= issued + CW'(1);
      if (res_ok) returned <= ret_nx;
      if (t_tvalid & !res_ok) err_unexpected <= 1'b1;
      if (upd) begin
        best_t   <= t_tdata;
        best_idx <= returned[IDX_W-1:0];
        found    <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          ray_axis_tready <= 1'b1;
          if (accept) begin
            ray_axis_tready <= 1'b0;
            ray_q    <= ray_axis_tdata;
            num_q    <= CW'(num_objs);
            issued   <= '0;
            returned <= '0;
            fetched  <= (num_objs != '0) ? CW'(1) : '0;
            best_t   <= INF;
            best_idx <= '0;
            found    <= 1'b0;
            if (num_objs == '0) begin
              state      <= OUTPUT;
              hit_tvalid <= 1'b1;
              hit_t      <= INF;
              hit_idx    <= '0;
              hit_miss   <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (beat && (issued + CW'(1) == num_q)) state <= DRAIN;
        end
        DRAIN: begin
          if (ret_nx == num_q) begin
            state      <= OUTPUT;
            hit_tvalid <= 1'b1;
            hit_t      <= nb_t;
            hit_idx    <= nb_idx;
            hit_miss   <= !nb_found;
          end
        end
        OUTPUT: begin
          if (hit_tready) begin
            hit_tvalid      <= 1'b0;
            ray_axis_tready <= 1'b1;
            state           <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ray_scene_sched.sv
// Directed bench for ray_scene_sched with a RAM model and an
// in-order intersector model that returns table-driven t values.
module tb_ray_scene_sched;

  localparam int SIZE  = 32;
  localparam int IDX_W = 10;
  localparam int DW    = 6 * SIZE;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [IDX_W-1:0] num_objs = '0;
  logic [DW-1:0]    ray_axis_tdata = '0;
  logic             ray_axis_tvalid = 1'b0;
  logic             ray_axis_tready;
  logic             mem_rd_en;
  logic [IDX_W-1:0] mem_addr;
  logic [DW-1:0]    mem_rdata = '0;
  logic             mem_is_cylinder = 1'b0;
  logic [DW-1:0]    isect_obj_tdata;
  logic             isect_obj_is_cylinder;
  logic             isect_obj_tvalid;
  logic             isect_obj_tready = 1'b1;
  logic [DW-1:0]    isect_ray_tdata;
  logic             isect_ray_tvalid;
  logic             isect_ray_tready = 1'b1;
  logic [SIZE-1:0]  t_tdata = '0;
  logic             t_undef = 1'b0;
  logic             t_tvalid = 1'b0;
  logic             t_tready;
  logic [SIZE-1:0]  hit_t;
  logic [IDX_W-1:0] hit_idx;
  logic             hit_miss;
  logic             hit_tvalid;
  logic             hit_tready = 1'b0;
  logic             err_unexpected;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] ram [0:15];
  logic          ram_cyl [0:15];
  logic [31:0]   res_t [0:15];
  logic          res_u [0:15];
  logic [DW-1:0] cur_ray = '0;
  logic          hold = 1'b0;
  logic          inj = 1'b0;
  logic          rand_mode = 1'b0;
  int            q[$];
  int            log_idx[$];
  logic          log_cyl[$];
  int            ray_bad = 0;
  int            rd_cnt = 0;

  always #5 aclk = ~aclk;

  ray_scene_sched #(.SIZE(SIZE), .IDX_W(IDX_W)) dut (
    .aclk                  (aclk),
    .aresetn               (aresetn),
    .num_objs              (num_objs),
    .ray_axis_tdata        (ray_axis_tdata),
    .ray_axis_tvalid       (ray_axis_tvalid),
    .ray_axis_tready       (ray_axis_tready),
    .mem_rd_en             (mem_rd_en),
    .mem_addr              (mem_addr),
    .mem_rdata             (mem_rdata),
    .mem_is_cylinder       (mem_is_cylinder),
    .isect_obj_tdata       (isect_obj_tdata),
    .isect_obj_is_cylinder (isect_obj_is_cylinder),
    .isect_obj_tvalid      (isect_obj_tvalid),
    .isect_obj_tready      (isect_obj_tready),
    .isect_ray_tdata       (isect_ray_tdata),
    .isect_ray_tvalid      (isect_ray_tvalid),
    .isect_ray_tready      (isect_ray_tready),
    .t_tdata               (t_tdata),
    .t_undef               (t_undef),
    .t_tvalid              (t_tvalid),
    .t_tready              (t_tready),
    .hit_t                 (hit_t),
    .hit_idx               (hit_idx),
    .hit_miss              (hit_miss),
    .hit_tvalid            (hit_tvalid),
    .hit_tready            (hit_tready),
    .err_unexpected        (err_unexpected)
  );

  // Synchronous object RAM: data one cycle after the read strobe.
  always @(posedge aclk) begin
    if (mem_rd_en) begin
      mem_rdata       <= ram[mem_addr[3:0]];
      mem_is_cylinder <= ram_cyl[mem_addr[3:0]];
    end
  end

  always @(posedge aclk) begin
    if (mem_rd_en) rd_cnt = rd_cnt + 1;
  end

  always @(negedge aclk) begin
    isect_obj_tready = rand_mode ? 1'($urandom % 2) : 1'b1;
  end

  // In-order intersector: one-cycle minimum latency per object.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      q.delete();
      t_tvalid <= 1'b0;
      t_tdata  <= '0;
      t_undef  <= 1'b0;
    end else begin
      if (!hold && q.size() > 0) begin
        int k;
        k = q.pop_front();
        t_tvalid <= 1'b1;
        t_tdata  <= res_t[k];
        t_undef  <= res_u[k];
      end else begin
        t_tvalid <= inj;
        t_tdata  <= 32'h3f80_0000;
        t_undef  <= 1'b0;
      end
      if (isect_obj_tvalid && isect_obj_tready && isect_ray_tready) begin
        q.push_back(int'(isect_obj_tdata[15:0]));
        log_idx.push_back(int'(isect_obj_tdata[15:0]));
        log_cyl.push_back(isect_obj_is_cylinder);
        if (isect_ray_tdata !== cur_ray || isect_ray_tvalid !== 1'b1)
          ray_bad = ray_bad + 1;
      end
    end
  end

  task automatic send_ray(input logic [DW-1:0] r, input int n);
    bit ok;
    ok = 0;
    cur_ray = r;
    ray_axis_tdata = r;
    num_objs = IDX_W'(n);
    ray_axis_tvalid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (ray_axis_tready) begin
        @(posedge aclk);
        #1;
        ok = 1;
      end else begin
        @(negedge aclk);
      end
    end
    ray_axis_tvalid = 1'b0;
    num_objs = '1;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL ray_accept: ray_axis_tready never 1 in 20 cycles, required 1");
    end
  endtask

  task automatic wait_hit(input string nm, input int max);
    bit got;
    got = 0;
    for (int k = 0; k < max && !got; k++) begin
      @(negedge aclk);
      if (hit_tvalid) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s_timeout: hit_tvalid=0 after %0d cycles, required 1", nm, max);
    end
  endtask

  task automatic ack_hit();
    @(negedge aclk);
    hit_tready = 1'b1;
    @(posedge aclk);
    #1;
    hit_tready = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    n_cmp++;
    if ({ray_axis_tready, hit_tvalid, hit_miss, hit_t, hit_idx,
         err_unexpected, mem_rd_en} !== {1'b0, 1'b0, 1'b1, 32'h0,
         10'h0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_vals: rdy=%b hv=%b miss=%b t=%h idx=%0d err=%b rd=%b, required 0 0 1 0 0 0 0",
               ray_axis_tready, hit_tvalid, hit_miss, hit_t, hit_idx,
               err_unexpected, mem_rd_en);
    end
    @(negedge aclk);
    n_cmp++;
    if ({ray_axis_tready, t_tready} !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_idle_ready: rdy=%b t_tready=%b, required 1 1",
               ray_axis_tready, t_tready);
    end
  endtask

  task automatic test_zero_objs();
    rd_cnt = 0;
    send_ray(192'h11, 0);
    wait_hit("zero", 3);
    n_cmp++;
    if ({hit_t, hit_idx, hit_miss} !== {32'h7f80_0000, 10'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL zero_hit: t=%h idx=%0d miss=%b, required 7f800000 0 1",
               hit_t, hit_idx, hit_miss);
    end
    n_cmp++;
    if (rd_cnt !== 0) begin
      n_bad++;
      $display("FAIL zero_rd: reads=%0d, required 0", rd_cnt);
    end
    ack_hit();
  endtask

  task automatic test_min3();
    res_t[0] = 32'h4040_0000; res_u[0] = 0;
    res_t[1] = 32'h3f80_0000; res_u[1] = 0;
    res_t[2] = 32'h4000_0000; res_u[2] = 0;
    log_idx.delete(); log_cyl.delete(); ray_bad = 0;
    send_ray(192'hABCD_0003_0000_0000_0000_0001, 3);
    wait_hit("min3", 40);
    n_cmp++;
    if ({hit_t, hit_idx, hit_miss} !== {32'h3f80_0000, 10'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL min3_hit: t=%h idx=%0d miss=%b, required 3f800000 1 0",
               hit_t, hit_idx, hit_miss);
    end
    n_cmp++;
    if (log_idx.size() !== 3 || ray_bad !== 0) begin
      n_bad++;
      $display("FAIL min3_issue: beats=%0d ray_bad=%0d, required 3 0",
               log_idx.size(), ray_bad);
    end
    ack_hit();
  endtask

  task automatic test_invalid4();
    res_t[0] = 32'h3f80_0000; res_u[0] = 1;
    res_t[1] = 32'hbf80_0000; res_u[1] = 0;
    res_t[2] = 32'h0000_0000; res_u[2] = 0;
    res_t[3] = 32'h7fc0_0000; res_u[3] = 0;
    send_ray(192'h44, 4);
    wait_hit("inv4", 40);
    n_cmp++;
    if ({hit_t, hit_idx, hit_miss} !== {32'h7f80_0000, 10'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL inv4_hit: t=%h idx=%0d miss=%b, required 7f800000 0 1",
               hit_t, hit_idx, hit_miss);
    end
    res_u[0] = 0;
    ack_hit();
  endtask

  task automatic test_stall5();
    res_t[0] = 32'h40a0_0000;
    res_t[1] = 32'h4080_0000;
    res_t[2] = 32'h4100_0000;
    res_t[3] = 32'h3f00_0000;
    res_t[4] = 32'h4000_0000;
    log_idx.delete(); log_cyl.delete(); ray_bad = 0;
    rand_mode = 1'b1;
    send_ray(192'h5555_0000_1234, 5);
    wait_hit("stall5", 80);
    rand_mode = 1'b0;
    n_cmp++;
    if (log_idx.size() !== 5 || ray_bad !== 0) begin
      n_bad++;
      $display("FAIL stall5_count: beats=%0d ray_bad=%0d, required 5 0",
               log_idx.size(), ray_bad);
    end
    for (int i = 0; i < 5 && i < log_idx.size(); i++) begin
      n_cmp++;
      if (log_idx[i] !== i || log_cyl[i] !== ram_cyl[i]) begin
        n_bad++;
        $display("FAIL stall5_beat%0d: idx=%0d cyl=%b, required %0d %b",
                 i, log_idx[i], log_cyl[i], i, ram_cyl[i]);
      end
    end
    n_cmp++;
    if ({hit_t, hit_idx, hit_miss} !== {32'h3f00_0000, 10'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL stall5_hit: t=%h idx=%0d miss=%b, required 3f000000 3 0",
               hit_t, hit_idx, hit_miss);
    end
    ack_hit();
  endtask

  task automatic test_tie_hold();
    res_t[0] = 32'h4040_0000;
    res_t[1] = 32'h4080_0000;
    res_t[2] = 32'h4000_0000;
    res_t[3] = 32'h40a0_0000;
    res_t[4] = 32'h4000_0000;
    send_ray(192'h66, 5);
    wait_hit("tie", 40);
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if ({hit_tvalid, hit_t, hit_idx, hit_miss, ray_axis_tready} !==
          {1'b1, 32'h4000_0000, 10'd2, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL tie_hold_c%0d: hv=%b t=%h idx=%0d miss=%b rdy=%b, required 1 40000000 2 0 0",
                 c, hit_tvalid, hit_t, hit_idx, hit_miss, ray_axis_tready);
      end
      @(negedge aclk);
    end
    ack_hit();
    n_cmp++;
    if ({hit_tvalid, ray_axis_tready} !== 2'b01) begin
      n_bad++;
      $display("FAIL tie_release: hv=%b rdy=%b, required 0 1",
               hit_tvalid, ray_axis_tready);
    end
  endtask

  task automatic test_back_to_back();
    res_t[0] = 32'h4120_0000;
    send_ray(192'h77, 1);
    wait_hit("b2b", 20);
    n_cmp++;
    if ({hit_t, hit_idx, hit_miss} !== {32'h4120_0000, 10'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL b2b_hit: t=%h idx=%0d miss=%b, required 41200000 0 0",
               hit_t, hit_idx, hit_miss);
    end
    ack_hit();
  endtask

  task automatic test_err_idle();
    inj = 1'b1;
    @(posedge aclk);
    #1;
    inj = 1'b0;
    repeat (2) @(negedge aclk);
    n_cmp++;
    if ({err_unexpected, hit_tvalid, ray_axis_tready} !== 3'b101) begin
      n_bad++;
      $display("FAIL err_set: err=%b hv=%b rdy=%b, required 1 0 1",
               err_unexpected, hit_tvalid, ray_axis_tready);
    end
    res_t[0] = 32'h3f80_0000;
    send_ray(192'h88, 1);
    wait_hit("err_ray", 20);
    ack_hit();
    n_cmp++;
    if (err_unexpected !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: err=%b, required 1", err_unexpected);
    end
  endtask

  task automatic test_reset_drain();
    bit got;
    got = 0;
    hold = 1'b1;
    log_idx.delete(); log_cyl.delete();
    send_ray(192'h99, 4);
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge aclk);
      if (log_idx.size() == 4) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL drain_reach: beats=%0d, required 4", log_idx.size());
    end
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    n_cmp++;
    if ({ray_axis_tready, hit_tvalid, isect_obj_tvalid, isect_ray_tvalid,
         mem_rd_en, t_tready, hit_miss, hit_t, hit_idx, err_unexpected} !==
        {6'b0, 1'b1, 32'h0, 10'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL drain_reset: rdy=%b hv=%b ov=%b rv=%b rd=%b tr=%b miss=%b t=%h idx=%0d err=%b, required 0 0 0 0 0 0 1 0 0 0",
               ray_axis_tready, hit_tvalid, isect_obj_tvalid,
               isect_ray_tvalid, mem_rd_en, t_tready, hit_miss, hit_t,
               hit_idx, err_unexpected);
    end
    hold = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    res_t[0] = 32'h4000_0000;
    res_t[1] = 32'h3f80_0000;
    send_ray(192'hAA, 2);
    wait_hit("recover", 30);
    n_cmp++;
    if ({hit_t, hit_idx, hit_miss, err_unexpected} !==
        {32'h3f80_0000, 10'd1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL recover_hit: t=%h idx=%0d miss=%b err=%b, required 3f800000 1 0 0",
               hit_t, hit_idx, hit_miss, err_unexpected);
    end
    ack_hit();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i]     = {8'(i), 168'h0, 16'(i)};
      ram_cyl[i] = 1'($urandom % 2);
      res_t[i]   = 32'h3f80_0000;
      res_u[i]   = 1'b0;
    end
    test_reset();
    test_zero_objs();
    test_min3();
    test_invalid4();
    test_stall5();
    test_tie_hold();
    test_back_to_back();
    test_err_idle();
    test_reset_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
